// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store unit memory controller.
// Optional feature macro used by the controller: LSU_MISALIGN_TRAP_EN.
package lsu_mem_ctrl_pkg;

  // Controller states: waiting for work, bus request outstanding, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Byte-enable patterns for a naturally aligned access at lane 0.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Load/store descriptor handed over by the EX operand-selection stage.
  typedef struct packed {
    logic [31:0] store_data;
    logic        load_en;
    logic        store_en;
    logic        lsu_byte;
    logic        lsu_halfword;
    logic        lsu_signed;
    logic        valid;
    logic [7:0]  debug_pkg;
  } lsu_t;

  // Byte enables for the access size; low address bits below the access
  // size are ignored so a misaligned halfword/word falls back to its container.
  function automatic logic [3:0] store_be(input logic       is_byte,
                                          input logic       is_half,
                                          input logic [1:0] lane);
    logic [3:0] be;
    if (is_byte) begin
      be = BE_BYTE << lane;
    end else if (is_half) begin
      be = lane[1] ? {BE_HALF[1:0], 2'b00} : BE_HALF;
    end else begin
      be = BE_WORD;
    end
    return be;
  endfunction

  // Replicate the store operand across every lane it could land in, so the
  // memory only has to honour the byte enables.
  function automatic logic [31:0] store_wdata(input logic        is_byte,
                                              input logic        is_half,
                                              input logic [31:0] data);
    logic [31:0] wdata;
    if (is_byte) begin
      wdata = {4{data[7:0]}};
    end else if (is_half) begin
      wdata = {2{data[15:0]}};
    end else begin
      wdata = data;
    end
    return wdata;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the bus
// word and sign- or zero-extends it to 32 bits. Word loads pass through.
module lsu_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic        byte_i,
  input  logic        half_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the bus word into its four byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = rdata_i[8*gi +: 8];
  end

  // Lane select followed by extension according to access size and signedness.
  always_comb begin
    byte_sel = lanes[addr_i];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    if (byte_i) begin
      result_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
    end else if (half_i) begin
      result_o = {{16{signed_i & half_sel[15]}}, half_sel};
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: req/ack bus handshake with timeout,
// store byte-enable/lane replication, load alignment and pipeline stall.
// Optional macro LSU_MISALIGN_TRAP_EN adds o_lsu_misaligned and refuses to
// issue misaligned halfword/word accesses instead of truncating the address.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  lsu_t        i_abt_lsu_pkg,
  input  logic [31:0] i_alu_addr,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_lsu_stall,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_rdata_valid,
  output logic        o_lsu_bus_err
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        o_lsu_misaligned
`endif
);

  lsu_state_e           state_q;
  logic                 req_q;
  logic                 we_q;
  logic [31:0]          addr_q;
  logic [3:0]           be_q;
  logic [31:0]          wdata_q;
  logic [1:0]           lane_q;
  logic                 byte_q;
  logic                 half_q;
  logic                 signed_q;
  logic                 killed_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;
  logic [31:0]          rdata_q;
  logic                 rdata_valid_q;
  logic                 bus_err_q;
  logic                 misaligned_q;

  logic                 is_byte;
  logic                 is_half;
  logic                 accept;
  logic                 misalign;
  logic                 issue;
  logic [3:0]           be_d;
  logic [31:0]          wdata_d;
  logic [31:0]          align_result;
  logic                 unused_dbg;

  // The debug side-band travels with the descriptor but has no role here.
  assign unused_dbg = ^i_abt_lsu_pkg.debug_pkg;

  // Byte wins over halfword if both flags are set; neither means word.
  assign is_byte = i_abt_lsu_pkg.lsu_byte;
  assign is_half = ~i_abt_lsu_pkg.lsu_byte & i_abt_lsu_pkg.lsu_halfword;

  // A new access is taken only from IDLE. The cycle carrying a bus-error or
  // misalignment pulse is excluded so the still-presented faulting
  // instruction is not re-accepted while the pipeline moves it along.
  assign accept = (state_q == IDLE) & i_abt_lsu_pkg.valid
                & (i_abt_lsu_pkg.load_en | i_abt_lsu_pkg.store_en)
                & ~i_flush & ~bus_err_q & ~misaligned_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (is_half & i_alu_addr[0])
                  | (~is_byte & ~is_half & (i_alu_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign issue   = accept & ~misalign;
  assign be_d    = store_be(is_byte, is_half, i_alu_addr[1:0]);
  assign wdata_d = store_wdata(is_byte, is_half, i_abt_lsu_pkg.store_data);
  assign cnt_d   = cnt_q + 1'b1;

  lsu_load_align u_align (
    .rdata_i  (i_mem_rdata),
    .addr_i   (lane_q),
    .byte_i   (byte_q),
    .half_i   (half_q),
    .signed_i (signed_q),
    .result_o (align_result)
  );

  // Controller FSM with all bus and result outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      lane_q        <= '0;
      byte_q        <= 1'b0;
      half_q        <= 1'b0;
      signed_q      <= 1'b0;
      killed_q      <= 1'b0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      misaligned_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q  <= REQ;
            req_q    <= 1'b1;
            we_q     <= i_abt_lsu_pkg.store_en;
            addr_q   <= {i_alu_addr[31:2], 2'b00};
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            lane_q   <= i_alu_addr[1:0];
            byte_q   <= is_byte;
            half_q   <= is_half;
            signed_q <= i_abt_lsu_pkg.lsu_signed;
            killed_q <= 1'b0;
            cnt_q    <= '0;
          end else if (accept) begin
            misaligned_q <= 1'b1;
          end
        end
        REQ: begin
          // A flush cannot abort the bus cycle; it only discards the result.
          if (i_flush) begin
            killed_q <= 1'b1;
          end
          if (i_mem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (!we_q && !killed_q && !i_flush) begin
              rdata_q       <= align_result;
              rdata_valid_q <= 1'b1;
            end
          end else if (&cnt_d) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req         = req_q;
  assign o_mem_we          = we_q;
  assign o_mem_addr        = addr_q;
  assign o_mem_be          = be_q;
  assign o_mem_wdata       = wdata_q;
  assign o_lsu_stall       = (state_q == REQ) | accept;
  assign o_lsu_rdata       = rdata_q;
  assign o_lsu_rdata_valid = rdata_valid_q;
  assign o_lsu_bus_err     = bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign o_lsu_misaligned  = misaligned_q;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl, built with a 4-bit timeout counter.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  lsu_t        pkg;
  logic [31:0] alu_addr;
  logic        flush;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        o_lsu_stall;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_rdata_valid;
  logic        o_lsu_bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        o_lsu_misaligned;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  lsu_mem_ctrl #(.TIMEOUT_W(4)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_abt_lsu_pkg     (pkg),
    .i_alu_addr        (alu_addr),
    .i_flush           (flush),
    .o_mem_req         (o_mem_req),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_be          (o_mem_be),
    .o_mem_wdata       (o_mem_wdata),
    .i_mem_ack         (mem_ack),
    .i_mem_rdata       (mem_rdata),
    .o_lsu_stall       (o_lsu_stall),
    .o_lsu_rdata       (o_lsu_rdata),
    .o_lsu_rdata_valid (o_lsu_rdata_valid),
    .o_lsu_bus_err     (o_lsu_bus_err)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .o_lsu_misaligned  (o_lsu_misaligned)
`endif
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic b, input logic h,
                        input logic s, input logic [31:0] addr, input logic [31:0] data);
    pkg.store_data   = data;
    pkg.load_en      = ld;
    pkg.store_en     = st;
    pkg.lsu_byte     = b;
    pkg.lsu_halfword = h;
    pkg.lsu_signed   = s;
    pkg.valid        = 1'b1;
    pkg.debug_pkg    = 8'h5A;
    alu_addr         = addr;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    pkg = '0; alu_addr = '0; flush = 0; mem_ack = 0; mem_rdata = '0;
    #12;
    n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", o_mem_req); end
    n_checks++; if (o_lsu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", o_lsu_stall); end
    n_checks++; if (o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", o_mem_addr); end
    n_checks++; if (o_mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_be got %b want 0000", o_mem_be); end
    n_checks++; if (o_lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", o_lsu_rdata); end
    n_checks++; if ({o_lsu_rdata_valid, o_lsu_bus_err, o_mem_we} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {o_lsu_rdata_valid, o_lsu_bus_err, o_mem_we}); end
    @(negedge i_clk); i_rst_n = 1'b1;
    tick();
    $display("reset: outputs cleared");
  endtask

  task automatic test_store_byte();
    set_op(0, 1, 1, 0, 0, 32'h0000_1003, 32'h0000_00A5); #1;
    n_checks++; if (o_lsu_stall !== 1'b1) begin n_fail++; $display("FAIL sb_accept_stall got %b want 1", o_lsu_stall); end
    n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL sb_accept_req got %b want 0", o_mem_req); end
    tick();
    n_checks++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL sb_req got %b want 1", o_mem_req); end
    n_checks++; if (o_mem_we !== 1'b1) begin n_fail++; $display("FAIL sb_we got %b want 1", o_mem_we); end
    n_checks++; if (o_mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr got %h want 00001000", o_mem_addr); end
    n_checks++; if (o_mem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b want 1000", o_mem_be); end
    n_checks++; if (o_mem_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata got %h want a5a5a5a5", o_mem_wdata); end
    mem_ack = 1'b1; #1;
    n_checks++; if (o_lsu_stall !== 1'b1) begin n_fail++; $display("FAIL sb_req_stall got %b want 1", o_lsu_stall); end
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({o_mem_req, o_lsu_stall, o_lsu_rdata_valid} !== 3'b000) begin n_fail++; $display("FAIL sb_done got req/stall/valid %b want 000", {o_mem_req, o_lsu_stall, o_lsu_rdata_valid}); end
    pkg.valid = 1'b0;
    tick();
    $display("store SB addr=00001003 data=a5 be=%b wdata=%h", o_mem_be, o_mem_wdata);
  endtask

  task automatic load_case(input string nm, input logic [31:0] addr, input logic b, input logic h,
                           input logic s, input logic [31:0] word, input logic [31:0] exp);
    set_op(1, 0, b, h, s, addr, 32'h0); #1;
    n_checks++; if (o_lsu_stall !== 1'b1) begin n_fail++; $display("FAIL %s_accept_stall got %b want 1", nm, o_lsu_stall); end
    tick();
    n_checks++; if ({o_mem_req, o_mem_we} !== 2'b10) begin n_fail++; $display("FAIL %s_req_we got %b want 10", nm, {o_mem_req, o_mem_we}); end
    n_checks++; if (o_mem_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_addr got %h want %h", nm, o_mem_addr, {addr[31:2], 2'b00}); end
    mem_ack = 1'b1; mem_rdata = word;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_checks++; if (o_lsu_rdata_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got %b want 1", nm, o_lsu_rdata_valid); end
    n_checks++; if (o_lsu_rdata !== exp) begin n_fail++; $display("FAIL %s_rdata got %h want %h", nm, o_lsu_rdata, exp); end
    n_checks++; if ({o_lsu_stall, o_mem_req} !== 2'b00) begin n_fail++; $display("FAIL %s_done_stall_req got %b want 00", nm, {o_lsu_stall, o_mem_req}); end
    pkg.valid = 1'b0;
    tick();
    n_checks++; if (o_lsu_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_pulse got %b want 0", nm, o_lsu_rdata_valid); end
    n_checks++; if (o_lsu_rdata !== exp) begin n_fail++; $display("FAIL %s_hold got %h want %h", nm, o_lsu_rdata, exp); end
    $display("load %s addr=%h word=%h result=%h", nm, addr, word, o_lsu_rdata);
  endtask

  task automatic test_loads();
    load_case("lb",  32'h0000_2002, 1, 0, 1, 32'h12F3_4567, 32'hFFFF_FFF3);
    load_case("lbu", 32'h0000_2002, 1, 0, 0, 32'h12F3_4567, 32'h0000_00F3);
    load_case("lh",  32'h0000_2002, 0, 1, 1, 32'h12F3_4567, 32'h0000_12F3);
    load_case("lh0", 32'h0000_2000, 0, 1, 1, 32'h0000_9ABC, 32'hFFFF_9ABC);
    load_case("lbu1", 32'h0000_2001, 1, 0, 0, 32'h12F3_4567, 32'h0000_0045);
  endtask

  task automatic test_wait_states();
    set_op(1, 0, 0, 0, 0, 32'h0000_3004, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
      #1;
      n_checks++; if ({o_mem_req, o_lsu_stall} !== 2'b11) begin n_fail++; $display("FAIL wait_req_stall cyc%0d got %b want 11", i, {o_mem_req, o_lsu_stall}); end
      n_checks++; if ({o_mem_addr, o_mem_be, o_mem_wdata} !== {32'h0000_3004, 4'b1111, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wait_bus cyc%0d got %h/%b/%h want 00003004/1111/deadbeef", i, o_mem_addr, o_mem_be, o_mem_wdata); end
      tick();
    end
    mem_ack = 1'b0;
    n_checks++; if ({o_lsu_rdata_valid, o_lsu_rdata} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL wait_result got %b/%h want 1/cafef00d", o_lsu_rdata_valid, o_lsu_rdata); end
    pkg.valid = 1'b0;
    tick();
    $display("load LW addr=00003004 three req cycles result=%h", o_lsu_rdata);
  endtask

  task automatic test_flush();
    set_op(1, 0, 1, 0, 1, 32'h0000_5001, 32'h0);
    flush = 1'b1; #1;
    n_checks++; if (o_lsu_stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got %b want 0", o_lsu_stall); end
    tick();
    n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_req got %b want 0", o_mem_req); end
    flush = 1'b0;
    tick();
    flush = 1'b1; #1;
    n_checks++; if ({o_mem_req, o_lsu_stall} !== 2'b11) begin n_fail++; $display("FAIL flush_req_stall got %b want 11", {o_mem_req, o_lsu_stall}); end
    tick();
    flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1122_3344; #1;
    n_checks++; if ({o_mem_req, o_lsu_stall} !== 2'b11) begin n_fail++; $display("FAIL flush_held_req got %b want 11", {o_mem_req, o_lsu_stall}); end
    tick();
    mem_ack = 1'b0;
    n_checks++; if (o_lsu_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", o_lsu_rdata_valid); end
    n_checks++; if (o_lsu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL flush_rdata got %h want cafef00d", o_lsu_rdata); end
    tick();
    set_op(1, 0, 0, 1, 1, 32'h0000_5002, 32'h0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h8001_0000;
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({o_lsu_rdata_valid, o_lsu_rdata} !== {1'b1, 32'hFFFF_8001}) begin n_fail++; $display("FAIL flush_next_load got %b/%h want 1/ffff8001", o_lsu_rdata_valid, o_lsu_rdata); end
    pkg.valid = 1'b0;
    tick();
    $display("flush: killed load dropped, next LH result=%h", o_lsu_rdata);
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_cycles = 0;
    int err_at = 0;
    int valid_cycles = 0;
    set_op(1, 0, 0, 0, 0, 32'h0000_4000, 32'h0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (o_mem_req) req_cycles++;
      if (o_lsu_rdata_valid) valid_cycles++;
      if (o_lsu_bus_err) begin
        err_cycles++;
        err_at = i;
        n_checks++; if (o_lsu_stall !== 1'b0) begin n_fail++; $display("FAIL timeout_err_stall got %b want 0", o_lsu_stall); end
        pkg.valid = 1'b0;
      end
    end
    n_checks++; if (req_cycles != 15) begin n_fail++; $display("FAIL timeout_req_cycles got %0d want 15", req_cycles); end
    n_checks++; if (err_cycles != 1) begin n_fail++; $display("FAIL timeout_err_pulses got %0d want 1", err_cycles); end
    n_checks++; if (err_at != 16) begin n_fail++; $display("FAIL timeout_err_cycle got %0d want 16", err_at); end
    n_checks++; if (valid_cycles != 0) begin n_fail++; $display("FAIL timeout_valid got %0d want 0", valid_cycles); end
    pkg.valid = 1'b0;
    $display("timeout: req cycles=%0d bus_err pulses=%0d", req_cycles, err_cycles);
  endtask

  task automatic test_ack_at_terminal();
    set_op(1, 0, 0, 0, 0, 32'h0000_4800, 32'h0);
    tick();
    repeat (14) tick();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
    n_checks++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL term_req got %b want 1", o_mem_req); end
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({o_lsu_rdata_valid, o_lsu_bus_err} !== 2'b10) begin n_fail++; $display("FAIL term_ack_wins got valid/err %b want 10", {o_lsu_rdata_valid, o_lsu_bus_err}); end
    n_checks++; if (o_lsu_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL term_rdata got %h want 0badf00d", o_lsu_rdata); end
    pkg.valid = 1'b0;
    tick();
    $display("ack on 15th req cycle: result=%h", o_lsu_rdata);
  endtask

  task automatic test_back_to_back();
    set_op(0, 1, 0, 1, 0, 32'h0000_6002, 32'h0000_BEEF);
    tick();
    n_checks++; if ({o_mem_be, o_mem_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin n_fail++; $display("FAIL sh_be_wdata got %b/%h want 1100/beefbeef", o_mem_be, o_mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    set_op(1, 1, 0, 0, 0, 32'h0000_6000, 32'h0123_4567);
    tick();
    n_checks++; if ({o_mem_we, o_mem_be, o_mem_wdata} !== {1'b1, 4'b1111, 32'h0123_4567}) begin n_fail++; $display("FAIL sw_both_en got %b/%b/%h want 1/1111/01234567", o_mem_we, o_mem_be, o_mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (o_lsu_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL sw_no_valid got %b want 0", o_lsu_rdata_valid); end
    pkg.valid = 1'b0;
    tick();
    $display("back-to-back SH then SW(load+store) issued");
  endtask

  task automatic test_misaligned();
    set_op(1, 0, 0, 0, 0, 32'h0000_1001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    #1;
    n_checks++; if (o_lsu_stall !== 1'b1) begin n_fail++; $display("FAIL mis_accept_stall got %b want 1", o_lsu_stall); end
    tick();
    n_checks++; if ({o_lsu_misaligned, o_mem_req, o_lsu_stall} !== 3'b100) begin n_fail++; $display("FAIL mis_pulse got mis/req/stall %b want 100", {o_lsu_misaligned, o_mem_req, o_lsu_stall}); end
    pkg.valid = 1'b0;
    tick();
    n_checks++; if ({o_lsu_misaligned, o_mem_req} !== 2'b00) begin n_fail++; $display("FAIL mis_after got %b want 00", {o_lsu_misaligned, o_mem_req}); end
    $display("misaligned LW addr=00001001 trapped");
`else
    tick();
    n_checks++; if ({o_mem_req, o_mem_addr, o_mem_be} !== {1'b1, 32'h0000_1000, 4'b1111}) begin n_fail++; $display("FAIL mis_trunc got %b/%h/%b want 1/00001000/1111", o_mem_req, o_mem_addr, o_mem_be); end
    mem_ack = 1'b1; mem_rdata = 32'h89AB_CDEF;
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({o_lsu_rdata_valid, o_lsu_rdata} !== {1'b1, 32'h89AB_CDEF}) begin n_fail++; $display("FAIL mis_word got %b/%h want 1/89abcdef", o_lsu_rdata_valid, o_lsu_rdata); end
    pkg.valid = 1'b0;
    tick();
    $display("misaligned LW addr=00001001 truncated to %h", o_mem_addr);
`endif
  endtask

  task automatic test_reset_mid_req();
    set_op(1, 0, 0, 0, 0, 32'h0000_7000, 32'h0);
    tick();
    n_checks++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL rstreq_pre got %b want 1", o_mem_req); end
    pkg.valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++; if ({o_mem_req, o_lsu_stall} !== 2'b00) begin n_fail++; $display("FAIL rstreq_drop got %b want 00", {o_mem_req, o_lsu_stall}); end
    @(negedge i_clk); i_rst_n = 1'b1;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({o_mem_req, o_lsu_rdata_valid} !== 2'b00) begin n_fail++; $display("FAIL rstreq_after got %b want 00", {o_mem_req, o_lsu_rdata_valid}); end
    $display("reset during REQ: request dropped");
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_loads();
    test_wait_states();
    test_flush();
    test_timeout();
    test_ack_at_terminal();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit directly downstream of the EX operand-selection stage.
- Consumes the lsu_t package (store data, load/store enables, size, signedness, valid) and the ALU-computed effective address.
- Runs a req/ack handshake to the data memory, generates byte enables and lane-replicated write data, and aligns/sign-extends load data.
- Stalls the pipeline while a bus access is outstanding.

Parameters:
- TIMEOUT_W, 8: width of the ack-wait counter; timeout fires after 2^TIMEOUT_W-1 cycles without ack.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_abt_lsu_pkg  in  lsu_t  store_data, load_en, store_en, lsu_byte, lsu_halfword, lsu_signed, valid, debug_pkg
- i_alu_addr  in  32  effective address from the ALU
- i_flush  in  1  pipeline flush (branch mispredict)
- o_mem_req  out  1  bus request, held until ack or timeout
- o_mem_we  out  1  1 = store
- o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_ack  in  1  bus acknowledge; rdata valid in the same cycle
- i_mem_rdata  in  32  bus read word
- o_lsu_stall  out  1  hold upstream stages
- o_lsu_rdata  out  32  aligned, extended load result
- o_lsu_rdata_valid  out  1  one-cycle load-result strobe
- o_lsu_bus_err  out  1  one-cycle timeout strobe

Behaviour:
- Reset: the async assertion of i_rst_n forces state IDLE and clears all registered outputs and the counter to 0. A reset arriving mid-REQ drops o_mem_req immediately, with no completion.
- Accept condition, evaluated in IDLE: valid & (load_en | store_en) & ~i_flush. If store_en and load_en are both set, the access is a store.
- In the accept cycle N, o_lsu_stall is high combinationally. Address, size, sign, we, be and wdata are registered at the end of cycle N.
- FSM IDLE -> REQ:
  - o_mem_req=1 from cycle N+1.
  - All bus outputs stay stable until ack.
  - o_lsu_stall=1 throughout REQ.
- REQ -> DONE on i_mem_ack:
  - Loads capture the aligned result into o_lsu_rdata.
  - DONE lasts 1 cycle: o_lsu_rdata_valid=1 for loads, o_lsu_stall=0.
  - DONE -> IDLE. A zero-wait ack gives load-result latency of 2 cycles after accept.
- REQ -> IDLE on timeout:
  - The counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches all-ones, o_mem_req drops and o_lsu_bus_err pulses 1 cycle. No rdata_valid is produced.
- Ack and terminal count in the same cycle: ack wins.
- Store byte enables and write data:
  - SB: be = 1<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111, wdata = data.
- Load alignment:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - Sign-extend if lsu_signed, otherwise zero-extend.
  - Word loads pass through unchanged.
  - o_lsu_rdata holds its value until the next load completes.
- Flush:
  - In IDLE, flush blocks acceptance.
  - In REQ, the bus transaction still completes (no abort) and stall stays high. A sticky "killed" bit suppresses o_lsu_rdata_valid and leaves o_lsu_rdata unchanged.
- Misalignment, without the optional feature: addr[1:0] is ignored for SW/LW, and addr[0] for SH/LH.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, is not issued.
  - Output o_lsu_misaligned (1 bit) pulses in the cycle after the accept cycle, with o_lsu_stall=0.
  - FSM stays in IDLE; no o_mem_req.
- Undefined: the port is absent and the low address bits are silently truncated as above.

Decomposition:
- Shared package:
  - lsu_state_e {IDLE, REQ, DONE}.
  - Constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
  - lsu_t stays where it is already defined.
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension.
  - Inputs: rdata, addr[1:0], byte, halfword, signed.
  - Output: 32-bit result.

Test Plan:
- SB at 0x1003, store_data 0x000000A5, ack at N+1 -> o_mem_be=1000, o_mem_wdata=0xA5A5A5A5, o_mem_addr=0x1000, o_mem_we=1.
- LB signed at 0x2002, rdata 0x12F34567 -> o_lsu_rdata=0xFFFFFFF3. LBU -> 0x000000F3. LH at 0x2002 -> 0x000012F3. rdata_valid is 1 cycle at N+2.
- LW with ack delayed 3 cycles -> o_mem_req and o_lsu_stall high 3 cycles, then DONE. o_mem_addr/be/wdata remain stable throughout.
- TIMEOUT_W=4, ack never asserted -> o_mem_req drops after 15 REQ cycles, o_lsu_bus_err pulses 1 cycle, FSM returns to IDLE.
- Load accepted, i_flush pulsed during REQ, then ack -> no rdata_valid and o_lsu_rdata unchanged. A second load accepted next cycle completes normally.
- LW at 0x1001 -> with LSU_MISALIGN_TRAP_EN: o_lsu_misaligned pulse, no req. Without the macro: o_mem_addr=0x1000, be=1111.
